// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/format side in, extended immediate side out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) ();
  logic              in_valid;
  logic              in_rdy;
  logic [2:0]        imm_sel;
  logic [31:0]       inst;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_rdy;
  logic [XLEN-1:0]   imm;
  logic [2:0]        out_sel;
  logic              out_noimm;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, imm_sel, inst, in_tag, out_rdy,
    input  in_rdy, out_valid, imm, out_sel, out_noimm, out_tag
  );

  modport slave (
    input  in_valid, imm_sel, inst, in_tag, out_rdy,
    output in_rdy, out_valid, imm, out_sel, out_noimm, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator: combinational format decode and formation,
// followed by either a two-entry skid buffer or a single output register.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int SKID        = 1,
  parameter int TAG_W       = 32
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);
  localparam int EW = XLEN + 4 + TAG_W;

  logic [31:0]     ins;
  logic [2:0]      sel_c;
  logic            noimm_c;
  logic [XLEN-1:0] imm_c;
  logic [EW-1:0]   entry_c;
  logic [EW-1:0]   main_reg;
  logic            main_valid_reg;
  logic            accept;
  logic            drain;

  assign ins = bus.inst;

  always_comb begin
    sel_c = bus.imm_sel;
    if (AUTO_DECODE != 0) begin
      case (ins[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: sel_c = 3'b000;
        7'b0011011:                         sel_c = (XLEN == 64) ? 3'b000 : 3'b111;
        7'b0100011:                         sel_c = 3'b001;
        7'b1100011:                         sel_c = 3'b010;
        7'b0110111, 7'b0010111:             sel_c = 3'b011;
        7'b1101111:                         sel_c = 3'b100;
        7'b1110011:                         sel_c = ins[14] ? 3'b101 : 3'b000;
        default:                            sel_c = 3'b111;
      endcase
    end
  end

  // Sized casts of signed operands sign-extend to XLEN; zimm is cast unsigned.
  always_comb begin
    noimm_c = 1'b0;
    imm_c   = '0;
    case (sel_c)
      3'b000:  imm_c = XLEN'($signed(ins[31:20]));
      3'b001:  imm_c = XLEN'($signed({ins[31:25], ins[11:7]}));
      3'b010:  imm_c = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'b011:  imm_c = XLEN'($signed({ins[31:12], 12'b0}));
      3'b100:  imm_c = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'b101:  imm_c = XLEN'(ins[19:15]);
      default: noimm_c = 1'b1;
    endcase
  end

  assign entry_c = {imm_c, sel_c, noimm_c, bus.in_tag};
  assign drain   = main_valid_reg && bus.out_rdy;

  generate
    if (SKID != 0) begin : g_skid
      logic [EW-1:0] skid_reg;
      logic          skid_valid_reg;

      assign bus.in_rdy = !skid_valid_reg;
      assign accept     = bus.in_valid && !skid_valid_reg;

      // Skid only ever holds the entry that arrived while main was stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_reg       <= '0;
          main_valid_reg <= 1'b0;
          skid_reg       <= '0;
          skid_valid_reg <= 1'b0;
        end else if (drain) begin
          if (skid_valid_reg) begin
            main_reg       <= skid_reg;
            skid_valid_reg <= 1'b0;
          end else if (accept) begin
            main_reg       <= entry_c;
          end else begin
            main_valid_reg <= 1'b0;
          end
        end else if (accept) begin
          if (main_valid_reg) begin
            skid_reg       <= entry_c;
            skid_valid_reg <= 1'b1;
          end else begin
            main_reg       <= entry_c;
            main_valid_reg <= 1'b1;
          end
        end
      end
    end else begin : g_single
      logic rdy;

      assign rdy        = !main_valid_reg || bus.out_rdy;
      assign bus.in_rdy = rdy;
      assign accept     = bus.in_valid && rdy;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_reg       <= '0;
          main_valid_reg <= 1'b0;
        end else if (accept) begin
          main_reg       <= entry_c;
          main_valid_reg <= 1'b1;
        end else if (drain) begin
          main_valid_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.out_valid = main_valid_reg;
  assign {bus.imm, bus.out_sel, bus.out_noimm, bus.out_tag} = main_reg;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Three imm_gen_pipe variants driven in lockstep, each checked against an arithmetic reference queue.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [31:0] inst;
  logic [2:0]  imm_sel;
  logic [31:0] in_tag;
  logic        out_rdy;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b0 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b1 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b2 ();

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .SKID(1), .TAG_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .SKID(1), .TAG_W(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .SKID(0), .TAG_W(32)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b0.in_valid = in_valid; assign b1.in_valid = in_valid; assign b2.in_valid = in_valid;
  assign b0.inst     = inst;     assign b1.inst     = inst;     assign b2.inst     = inst;
  assign b0.imm_sel  = imm_sel;  assign b1.imm_sel  = imm_sel;  assign b2.imm_sel  = imm_sel;
  assign b0.in_tag   = in_tag;   assign b1.in_tag   = in_tag;   assign b2.in_tag   = in_tag;
  assign b0.out_rdy  = out_rdy;  assign b1.out_rdy  = out_rdy;  assign b2.out_rdy  = out_rdy;

  logic        obs_rdy   [3];
  logic        obs_valid [3];
  logic [63:0] obs_imm   [3];
  logic [2:0]  obs_sel   [3];
  logic        obs_noimm [3];
  logic [31:0] obs_tag   [3];

  assign obs_rdy[0]   = b0.in_rdy;          assign obs_rdy[1]   = b1.in_rdy;    assign obs_rdy[2]   = b2.in_rdy;
  assign obs_valid[0] = b0.out_valid;       assign obs_valid[1] = b1.out_valid; assign obs_valid[2] = b2.out_valid;
  assign obs_imm[0]   = {32'b0, b0.imm};    assign obs_imm[1]   = b1.imm;       assign obs_imm[2]   = {32'b0, b2.imm};
  assign obs_sel[0]   = b0.out_sel;         assign obs_sel[1]   = b1.out_sel;   assign obs_sel[2]   = b2.out_sel;
  assign obs_noimm[0] = b0.out_noimm;       assign obs_noimm[1] = b1.out_noimm; assign obs_noimm[2] = b2.out_noimm;
  assign obs_tag[0]   = b0.out_tag;         assign obs_tag[1]   = b1.out_tag;   assign obs_tag[2]   = b2.out_tag;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        noimm;
    logic [31:0] tag;
  } ent_t;

  ent_t sb [3][$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int w);
    if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: variant 0/2 = XLEN 32 with imm_sel, variant 1 = XLEN 64 with opcode decode.
  function automatic ent_t model(input int k, input logic [31:0] w, input logic [2:0] s_in, input logic [31:0] tag);
    ent_t   e;
    longint u;
    longint v;
    int     s;
    int     op;
    u = longint'(w);
    s = int'(s_in);
    e.noimm = 1'b0;
    if (k == 1) begin
      op = int'(u & 127);
      case (op)
        3, 19, 103: s = 0;
        27:         s = 0;
        35:         s = 1;
        99:         s = 2;
        55, 23:     s = 3;
        111:        s = 4;
        115:        s = (((u >> 14) & 1) == 1) ? 5 : 0;
        default:    s = 7;
      endcase
    end
    case (s)
      0: v = sext((u >> 20) & 4095, 12);
      1: v = sext(((u >> 25) & 127) * 32 + ((u >> 7) & 31), 12);
      2: v = sext(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
      3: v = sext((u >> 12) * 4096, 32);
      4: v = sext(((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2, 21);
      5: v = (u >> 15) & 31;
      default: begin v = 0; e.noimm = 1'b1; end
    endcase
    e.imm = 64'(v);
    if (k != 1) e.imm[63:32] = 32'b0;
    e.sel = 3'(s);
    e.tag = tag;
    return e;
  endfunction

  // One clock: check every variant against its queue, then advance the queues.
  task automatic step();
    bit   acc [3];
    bit   drn [3];
    bit   er;
    ent_t e;
    #1;
    for (int k = 0; k < 3; k++) begin
      er = (k == 2) ? (sb[k].size() == 0 || out_rdy) : (sb[k].size() < 2);
      chk($sformatf("d%0d.in_rdy", k), 64'(obs_rdy[k]), 64'(er));
      chk($sformatf("d%0d.out_valid", k), 64'(obs_valid[k]), 64'(sb[k].size() != 0));
      if (sb[k].size() != 0) begin
        e = sb[k][0];
        chk($sformatf("d%0d.imm", k), obs_imm[k], e.imm);
        chk($sformatf("d%0d.out_sel", k), 64'(obs_sel[k]), 64'(e.sel));
        chk($sformatf("d%0d.out_noimm", k), 64'(obs_noimm[k]), 64'(e.noimm));
        chk($sformatf("d%0d.out_tag", k), 64'(obs_tag[k]), 64'(e.tag));
      end
      acc[k] = in_valid && er;
      drn[k] = (sb[k].size() != 0) && out_rdy;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (drn[k]) void'(sb[k].pop_front());
      if (acc[k]) sb[k].push_back(model(k, inst, imm_sel, in_tag));
    end
  endtask

  initial begin
    logic [31:0] sw_inst [8];
    logic [2:0]  sw_sel  [8];
    logic [31:0] sw_imm  [8];
    int          ops     [12];
    int          tagn;
    bit          adv;

    sw_inst = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800002B7,
                32'hFFDFF06F, 32'h0007D073, 32'h00A50533, 32'h12345678};
    sw_sel  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110};
    sw_imm  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000,
                32'hFFFFFFFC, 32'h0000000F, 32'h0000000A, 32'h00000000};
    ops     = '{3, 19, 103, 27, 35, 99, 55, 23, 111, 115, 51, 15};

    rst_n = 1'b0; in_valid = 1'b0; inst = '0; imm_sel = '0; in_tag = '0; out_rdy = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst d%0d.in_rdy", k), 64'(obs_rdy[k]), 64'd1);
      chk($sformatf("rst d%0d.out_valid", k), 64'(obs_valid[k]), 64'd0);
      chk($sformatf("rst d%0d.imm", k), obs_imm[k], 64'd0);
      chk($sformatf("rst d%0d.out_sel", k), 64'(obs_sel[k]), 64'd0);
      chk($sformatf("rst d%0d.out_noimm", k), 64'(obs_noimm[k]), 64'd0);
      chk($sformatf("rst d%0d.out_tag", k), 64'(obs_tag[k]), 64'd0);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed format sweep at full rate: each result appears one cycle after its accept.
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; inst = sw_inst[i]; imm_sel = sw_sel[i]; in_tag = 32'(100 + i);
      step();
      chk($sformatf("sweep%0d.valid", i), 64'(b0.out_valid), 64'd1);
      chk($sformatf("sweep%0d.imm", i), 64'(b0.imm), 64'(sw_imm[i]));
      chk($sformatf("sweep%0d.sel", i), 64'(b0.out_sel), 64'(sw_sel[i]));
      chk($sformatf("sweep%0d.noimm", i), 64'(b0.out_noimm), 64'(i == 7));
      if (i == 3) begin
        chk("auto.lui.sel", 64'(b1.out_sel), 64'd3);
        chk("auto.lui.imm", b1.imm, 64'hFFFFFFFF80000000);
      end
      if (i == 6) begin
        chk("auto.rtype.noimm", 64'(b1.out_noimm), 64'd1);
        chk("auto.rtype.sel", 64'(b1.out_sel), 64'd7);
        chk("auto.rtype.imm", b1.imm, 64'd0);
      end
    end
    in_valid = 1'b0;
    step();

    // Backpressure: tags 1..6 with out_rdy low for three cycles.
    tagn = 1;
    for (int c = 1; c <= 14; c++) begin
      out_rdy  = !(c >= 2 && c <= 4);
      in_valid = (tagn <= 6);
      inst     = $urandom; imm_sel = 3'($urandom_range(0, 5)); in_tag = 32'(tagn);
      adv      = in_valid && (sb[0].size() < 2);
      step();
      if (adv) tagn++;
    end

    // Single-register variant at full rate, then combinational in_rdy drop.
    out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; inst = $urandom; imm_sel = 3'($urandom_range(0, 7)); in_tag = 32'(200 + c);
      step();
    end
    out_rdy = 1'b0;
    #1;
    chk("skid0.in_rdy_drop", 64'(b2.in_rdy), 64'd0);
    step();

    // Random traffic over all formats and opcodes.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_rdy  = ($urandom_range(0, 9) < 7);
      inst     = {$urandom_range(0, 32'h01FFFFFF) & 32'h01FFFFFF, 7'b0} | 32'($urandom) & 32'hFFFFFF80;
      inst[6:0] = 7'(ops[$urandom_range(0, 11)]);
      imm_sel  = 3'($urandom_range(0, 7));
      in_tag   = $urandom;
      step();
    end

    // Fill both entries, then reset between edges.
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; inst = $urandom; imm_sel = 3'b000; in_tag = 32'(300 + c);
      step();
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst d%0d.out_valid", k), 64'(obs_valid[k]), 64'd0);
      chk($sformatf("midrst d%0d.in_rdy", k), 64'(obs_rdy[k]), 64'd1);
      sb[k].delete();
    end
    #1 rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3); inst = $urandom; imm_sel = 3'b011; in_tag = 32'(400 + c);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
